// File: rtl/aw_vram_pkg.sv
// ============================================================================
// Module   : aw_vram_pkg
// Brief    : Shared widths and read-owner tag encoding for the VRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aw_vram_pkg;

  localparam int ADDR_W_DEF       = 17;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_DRAW = 2'd2,
    OWN_COPY = 2'd3
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/aw_rr_arb2.sv
// ============================================================================
// Module   : aw_rr_arb2
// Brief    : Two-input round-robin pick; pointer flips on every taken grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aw_rr_arb2 #(
  parameter bit EN_PTR = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic adv_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_w;

  generate
    if (EN_PTR) begin : g_ptr
      logic ptr_q;
      logic ptr_d;

      assign ptr_d = adv_i ? ~ptr_q : ptr_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ptr_q <= 1'b0;
        end else begin
          ptr_q <= ptr_d;
        end
      end

      assign ptr_w = ptr_q;
    end else begin : g_no_ptr
      logic unused_w;
      assign unused_w = ^{clk_i, rst_ni, adv_i};
      assign ptr_w    = 1'b0;
    end
  endgenerate

  // ptr_w = 0 favours req0 when both inputs contend.
  assign gnt0_o = req0_i & (~req1_i | ~ptr_w);
  assign gnt1_o = req1_i & (~req0_i |  ptr_w);

endmodule

`default_nettype wire

// File: rtl/aw_vram_arbiter.sv
// ============================================================================
// Module   : aw_vram_arbiter
// Brief    : Display/draw/copy arbiter for a single-port synchronous VRAM.
//            Copy port is arbitrated only when AW_VRAM_COPY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aw_vram_arbiter
  import aw_vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_ack,
  output logic [DATA_W-1:0] draw_rdata,
  output logic              draw_rvalid,
  input  logic              copy_req,
  input  logic              copy_we,
  input  logic [ADDR_W-1:0] copy_addr,
  input  logic [DATA_W-1:0] copy_wdata,
  output logic              copy_ack,
  output logic [DATA_W-1:0] copy_rdata,
  output logic              copy_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic copy_req_w;
`ifdef AW_VRAM_COPY_EN
  localparam bit COPY_EN = 1'b1;
  assign copy_req_w = copy_req;
`else
  localparam bit COPY_EN = 1'b0;
  logic unused_copy_w;
  assign unused_copy_w = copy_req;
  assign copy_req_w    = 1'b0;
`endif

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  owner_e            tag0_q, tag1_q, owner_d;

  logic rr_draw_w, rr_copy_w;
  logic forced_w, disp_win_w, pending_w;
  logic disp_ack_w, draw_ack_w, copy_ack_w;

  assign pending_w  = draw_req | copy_req_w;
  assign forced_w   = (starve_q == CNT_W'(STARVE_LIMIT));
  assign disp_win_w = disp_req & ~forced_w;

  aw_rr_arb2 #(
    .EN_PTR (COPY_EN)
  ) u_rr (
    .clk_i  (clk),
    .rst_ni (reset),
    .req0_i (draw_req),
    .req1_i (copy_req_w),
    .adv_i  (draw_ack_w | copy_ack_w),
    .gnt0_o (rr_draw_w),
    .gnt1_o (rr_copy_w)
  );

  // Acks are forced low while reset is asserted so nothing is granted.
  assign disp_ack_w = reset & disp_win_w;
  assign draw_ack_w = reset & ~disp_win_w & rr_draw_w;
  assign copy_ack_w = reset & ~disp_win_w & rr_copy_w;

  always_comb begin
    owner_d     = OWN_NONE;
    mem_en_d    = disp_ack_w | draw_ack_w | copy_ack_w;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;

    if (disp_ack_w) begin
      owner_d     = OWN_DISP;
      mem_addr_d  = disp_addr;
      mem_wdata_d = '0;
    end else if (draw_ack_w) begin
      owner_d     = draw_we ? OWN_NONE : OWN_DRAW;
      mem_we_d    = draw_we;
      mem_addr_d  = draw_addr;
      mem_wdata_d = draw_wdata;
    end else if (copy_ack_w) begin
      owner_d     = copy_we ? OWN_NONE : OWN_COPY;
      mem_we_d    = copy_we;
      mem_addr_d  = copy_addr;
      mem_wdata_d = copy_wdata;
    end

    if (draw_ack_w || copy_ack_w || !pending_w) begin
      starve_d = '0;
    end else if (disp_ack_w && !forced_w) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= '0;
      tag0_q      <= OWN_NONE;
      tag1_q      <= OWN_NONE;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
      tag0_q      <= owner_d;
      tag1_q      <= tag0_q;
    end
  end

  assign disp_ack  = disp_ack_w;
  assign draw_ack  = draw_ack_w;
  assign copy_ack  = copy_ack_w;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // tag1_q lines up with the RAM output cycle of the tagged read.
  assign disp_rvalid = (tag1_q == OWN_DISP);
  assign draw_rvalid = (tag1_q == OWN_DRAW);
  assign copy_rvalid = COPY_EN & (tag1_q == OWN_COPY);
  assign disp_rdata  = mem_rdata;
  assign draw_rdata  = mem_rdata;
  assign copy_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_aw_vram_arbiter.sv
// ============================================================================
// Module   : tb_aw_vram_arbiter
// Brief    : Scoreboard bench for aw_vram_arbiter with a behavioural VRAM.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aw_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  typedef struct {
    logic [2:0]    vec;
    logic [DW-1:0] data;
  } rd_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          disp_req = 1'b0, draw_req = 1'b0, copy_req = 1'b0;
  logic          draw_we = 1'b0, copy_we = 1'b0;
  logic [AW-1:0] disp_addr = '0, draw_addr = '0, copy_addr = '0;
  logic [DW-1:0] draw_wdata = '0, copy_wdata = '0;
  logic          disp_ack, draw_ack, copy_ack;
  logic          disp_rvalid, draw_rvalid, copy_rvalid;
  logic [DW-1:0] disp_rdata, draw_rdata, copy_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] vram [0:(1<<AW)-1];

  logic [2:0] ack_q [$];
  rd_t        rd_q  [$];
  mem_t       mem_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aw_vram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_ack    (disp_ack),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .draw_req    (draw_req),
    .draw_we     (draw_we),
    .draw_addr   (draw_addr),
    .draw_wdata  (draw_wdata),
    .draw_ack    (draw_ack),
    .draw_rdata  (draw_rdata),
    .draw_rvalid (draw_rvalid),
    .copy_req    (copy_req),
    .copy_we     (copy_we),
    .copy_addr   (copy_addr),
    .copy_wdata  (copy_wdata),
    .copy_ack    (copy_ack),
    .copy_rdata  (copy_rdata),
    .copy_rvalid (copy_rvalid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Single-port synchronous VRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are already applied; queue what this cycle must produce, then
  // advance past the next rising edge.
  task automatic cycle(input logic [2:0] ack, input logic exp_rd, input logic [DW-1:0] rdat);
    mem_t m;
    rd_t  r;
    ack_q.push_back(ack);
    if (ack != 3'b000) begin
      if (ack[0]) begin
        m.we = 1'b0; m.addr = disp_addr; m.wdata = '0;
      end else if (ack[1]) begin
        m.we = draw_we; m.addr = draw_addr; m.wdata = draw_wdata;
      end else begin
        m.we = copy_we; m.addr = copy_addr; m.wdata = copy_wdata;
      end
      mem_q.push_back(m);
      if (exp_rd && !m.we) begin
        r.vec = ack; r.data = rdat;
        rd_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_acks",    {29'd0, copy_ack, draw_ack, disp_ack}, 32'd0);
    chk("rst_rvalids", {29'd0, copy_rvalid, draw_rvalid, disp_rvalid}, 32'd0);
    chk("rst_mem_en",  {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr",  {15'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
  endtask

  logic [2:0]    mon_ack, mon_rv;
  mem_t          mon_m;
  rd_t           mon_r;
  logic [DW-1:0] mon_d;

  always @(negedge clk) begin
    if (ack_q.size() > 0) begin
      mon_ack = ack_q.pop_front();
      chk("ack", {29'd0, copy_ack, draw_ack, disp_ack}, {29'd0, mon_ack});
    end
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        chk("mem_en_unexpected", {31'd0, mem_en}, 32'd0);
      end else begin
        mon_m = mem_q.pop_front();
        chk("mem_we",   {31'd0, mem_we}, {31'd0, mon_m.we});
        chk("mem_addr", {15'd0, mem_addr}, {15'd0, mon_m.addr});
        if (mon_m.we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, mon_m.wdata});
      end
    end
    mon_rv = {copy_rvalid, draw_rvalid, disp_rvalid};
    if (mon_rv != 3'b000) begin
      if (rd_q.size() == 0) begin
        chk("rvalid_unexpected", {29'd0, mon_rv}, 32'd0);
      end else begin
        mon_r = rd_q.pop_front();
        mon_d = mon_rv[2] ? copy_rdata : (mon_rv[1] ? draw_rdata : disp_rdata);
        chk("rvalid_owner", {29'd0, mon_rv}, {29'd0, mon_r.vec});
        chk("rdata", {24'd0, mon_d}, {24'd0, mon_r.data});
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) vram[i] = i[7:0];

    // Reset state, with requests present to show acks stay low.
    disp_req = 1'b1;
    draw_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    disp_req = 1'b0;
    draw_req = 1'b0;
    reset    = 1'b1;

    // Back-to-back display reads, first one on the first edge after reset.
    for (int n = 0; n < 4; n++) begin
      disp_req  = 1'b1;
      disp_addr = AW'(n);
      cycle(3'b001, 1'b1, DW'(n));
    end

    // Starvation: display wins 8 cycles, draw write forced on the 9th.
    disp_addr  = 17'h00020;
    draw_req   = 1'b1;
    draw_we    = 1'b1;
    draw_addr  = 17'h00010;
    draw_wdata = 8'hA5;
    for (int i = 1; i <= 8; i++) cycle(3'b001, 1'b1, 8'h20);
    cycle(3'b010, 1'b1, 8'h00);
    disp_req = 1'b0;
    draw_we  = 1'b0;
    cycle(3'b010, 1'b1, 8'hA5);

`ifdef AW_VRAM_COPY_EN
    // Two draw grants above leave the pointer favouring draw.
    draw_addr = 17'h00040;
    copy_req  = 1'b1;
    copy_we   = 1'b0;
    copy_addr = 17'h00041;
    for (int i = 0; i < 2; i++) begin
      cycle(3'b010, 1'b1, 8'h40);
      cycle(3'b100, 1'b1, 8'h41);
    end
    draw_req = 1'b0;
    copy_req = 1'b0;
`else
    draw_addr = 17'h00042;
    copy_req  = 1'b1;
    cycle(3'b010, 1'b1, 8'h42);
    draw_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      copy_we    = i[0];
      copy_addr  = AW'(i + 'h100);
      copy_wdata = 8'h3C;
      cycle(3'b000, 1'b1, 8'h00);
    end
    copy_req = 1'b0;
    copy_we  = 1'b0;
`endif

    // Read in flight when reset hits is never returned.
    disp_req  = 1'b1;
    disp_addr = 17'h00005;
    cycle(3'b001, 1'b0, 8'h00);
    disp_req = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    disp_req = 1'b1;
    draw_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    draw_req  = 1'b0;
    disp_addr = 17'h00003;
    cycle(3'b001, 1'b1, 8'h03);
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle(3'b000, 1'b1, 8'h00);

    chk("ack_q_left", ack_q.size(), 32'd0);
    chk("mem_q_left", mem_q.size(), 32'd0);
    chk("rd_q_left",  rd_q.size(),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
